dbg_bus_master: RTL and testbench



---
 rtl/dbg_bus_master.sv | 99 +++++++++
 tb/tb_dbg_bus_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_master.sv
// dbg_bus_master: UART-byte-stream debug initiator issuing single-word reads/writes on the data bus.
module dbg_bus_master #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_WR         = 8'h57,
  parameter logic [7:0]  CMD_RD         = 8'h52
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        m_wr,
  output logic [31:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_rd,
  output logic [31:0] m_raddr,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WR, RD, RCAP, RESP} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t        state, state_nx;
  logic [TW-1:0] tmo;
  logic [1:0]    cnt, rem;
  logic          op_wr, timeout;
  logic [31:0]   addr, wdata, resp;
  assign timeout  = !rx_valid && tmo == TW'(TIMEOUT_CYCLES - 1);
  // Outputs decode straight from state so the async reset clears them at once.
  assign busy     = state != IDLE;
  assign bus_req  = state == REQ || state == WR || state == RD || state == RCAP;
  assign m_wr     = state == WR;
  assign m_rd     = state == RD;
  assign m_wstrb  = {4{m_wr}};
  assign m_waddr  = {addr[31:2], 2'b00};
  assign m_raddr  = {addr[31:2], 2'b00};
  assign m_wdata  = wdata;
  assign tx_valid = state == RESP;
  assign tx_data  = resp[7:0];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_valid) state_nx = (rx_data == CMD_WR || rx_data == CMD_RD) ? ADDR : RESP;
      ADDR: state_nx = (rx_valid && cnt == 2'd3) ? (op_wr ? DATA : REQ) : timeout ? IDLE : ADDR;
      DATA: state_nx = (rx_valid && cnt == 2'd3) ? REQ : timeout ? IDLE : DATA;
      REQ:  if (bus_gnt) state_nx = op_wr ? WR : RD;
      WR:   state_nx = RESP;
      RD:   state_nx = RCAP;
      RCAP: state_nx = RESP;
      RESP: if (tx_ready && rem == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      op_wr <= 1'b0;
      cnt   <= '0;
      rem   <= '0;
      tmo   <= '0;
      addr  <= '0;
      wdata <= '0;
      resp  <= '0;
    end else
      case (state)
        IDLE: if (rx_valid) begin
          op_wr <= rx_data == CMD_WR;
          cnt   <= '0;
          tmo   <= '0;
          resp  <= 32'h3F;
          rem   <= '0;
        end
        ADDR, DATA: if (rx_valid) begin
          cnt <= cnt + 2'd1;
          tmo <= '0;
          if (state == ADDR) addr <= {rx_data, addr[31:8]};
          else wdata <= {rx_data, wdata[31:8]};
        end else tmo <= tmo + TW'(1);
        WR: begin
          resp <= 32'h4B;
          rem  <= '0;
        end
        RCAP: begin
          resp <= m_rdata;
          rem  <= 2'd3;
        end
        RESP: if (tx_ready) begin
          resp <= resp >> 8;
          rem  <= rem - 2'd1;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_dbg_bus_master.sv
// tb_dbg_bus_master: randomized scoreboard bench for the debug bus master against a word-memory model.
module tb_dbg_bus_master;
  logic        clk = 0, rstn = 0;
  logic        rx_valid = 0, tx_ready = 0, bus_gnt = 0;
  logic [7:0]  rx_data = 0;
  logic [31:0] m_rdata = 0;
  logic        tx_valid, bus_req, m_wr, m_rd, busy;
  logic [7:0]  tx_data;
  logic [31:0] m_waddr, m_wdata, m_raddr;
  logic [3:0]  m_wstrb;
  always #5 clk = ~clk;
  dbg_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .m_wr(m_wr), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rd(m_rd), .m_raddr(m_raddr),
    .m_rdata(m_rdata), .busy(busy)
  );
  int          checks = 0, errors = 0;
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  logic        tx_manual = 0, gnt_rand = 1, gnt_val = 0, saw_req = 0;
  logic [63:0] mon_e;
  logic [31:0] mon_a;
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a transferred byte.
  always @(negedge clk) if (rstn) begin
    if (bus_req) saw_req = 1;
    if (m_wr) begin
      check("m_wr expected", exp_wr.size() != 0, 1);
      check("m_wstrb", m_wstrb, 4'hF);
      if (exp_wr.size() != 0) begin
        mon_e = exp_wr.pop_front();
        check("m_waddr", m_waddr, mon_e[63:32]);
        check("m_wdata", m_wdata, mon_e[31:0]);
      end
      slave_mem[m_waddr] = m_wdata;
    end
    if (m_rd) begin
      check("m_rd expected", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) begin
        mon_a = exp_rd.pop_front();
        check("m_raddr", m_raddr, mon_a);
      end
    end
    if (tx_valid && tx_ready) begin
      check("tx byte expected", exp_tx.size() != 0, 1);
      if (exp_tx.size() != 0) check("tx_data", tx_data, exp_tx.pop_front());
    end
  end
  // Bus slave: read data is valid only in the cycle after m_rd, garbage otherwise.
  initial begin
    logic [31:0] ra;
    forever begin
      @(negedge clk);
      if (rstn && m_rd) begin
        ra = m_raddr;
        @(posedge clk);
        #1 m_rdata = slave_mem.exists(ra) ? slave_mem[ra] : dflt(ra);
        @(posedge clk);
        #1 m_rdata = $urandom;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (!tx_manual) tx_ready = ($urandom % 4) != 0;
    bus_gnt = gnt_rand ? ($urandom % 3) != 0 : gnt_val;
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      if (gaps) idle($urandom % 3);
    end
  endtask
  task automatic cmd_wr(input logic [31:0] a, input logic [31:0] d, input bit gaps);
    exp_wr.push_back({a & ~32'h3, d});
    exp_tx.push_back(8'h4B);
    model_mem[a & ~32'h3] = d;
    send(8'h57);
    send_word(a, gaps);
    send_word(d, gaps);
  endtask
  task automatic cmd_rd(input logic [31:0] a, input bit gaps);
    logic [31:0] v;
    v = model_rd(a & ~32'h3);
    exp_rd.push_back(a & ~32'h3);
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
    send(8'h52);
    send_word(a, gaps);
  endtask
  task automatic cmd_bad(input logic [7:0] b);
    exp_tx.push_back(8'h3F);
    send(b);
  endtask
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      idle(1);
      n++;
    end
    check({name, " busy cleared"}, busy, 0);
    check({name, " scoreboard drained"}, exp_tx.size() + exp_wr.size() + exp_rd.size(), 0);
  endtask
  task automatic wait_tx();
    int n;
    n = 0;
    while (!tx_valid && n < 100) begin
      idle(1);
      n++;
    end
    check("tx_valid appears", tx_valid, 1);
  endtask
  initial begin
    int n, bad;
    logic [31:0] a, d;
    logic [7:0]  b;
    repeat (3) @(posedge clk);
    #1 check("reset outputs", {tx_valid, bus_req, busy, m_wr, m_rd, m_wstrb, tx_data, m_waddr, m_raddr}, 0);
    rstn = 1;
    idle(1);
    gnt_rand = 0;
    gnt_val  = 1;
    cmd_wr(32'h0100_0000, 32'hDEAD_BEEF, 0);
    wait_done("write");
    model_mem[32'h0300_0004] = 32'h1234_5678;
    slave_mem[32'h0300_0004] = 32'h1234_5678;
    tx_manual = 1;
    tx_ready  = 0;
    cmd_rd(32'h0300_0004, 0);
    wait_tx();
    tx_ready = 1;
    idle(2);
    tx_ready = 0;
    repeat (5) begin
      check("held tx_data", {tx_valid, tx_data}, {1'b1, 8'h34});
      idle(1);
    end
    tx_ready = 1;
    wait_done("read hold");
    tx_manual = 0;
    gnt_val = 0;
    cmd_rd(32'h0000_0040, 0);
    bad = 0;
    repeat (20) begin
      if (!bus_req || m_rd) bad++;
      idle(1);
    end
    check("grant wait cycles bad", bad, 0);
    gnt_val = 1;
    idle(1);
    check("m_rd after grant", m_rd, 1);
    wait_done("grant wait");
    gnt_rand = 1;
    saw_req  = 0;
    cmd_bad(8'h41);
    wait_done("unknown byte");
    check("unknown byte bus_req", saw_req, 0);
    send(8'h57);
    send(8'h01);
    send(8'h02);
    n = 0;
    while (busy && n < 100) begin
      idle(1);
      n++;
    end
    check("timeout cycles", n, 16);
    check("timeout busy", busy, 0);
    cmd_rd(32'h0000_0000, 0);
    wait_done("read after timeout");
    cmd_rd(32'h0100_0007, 0);
    wait_done("misaligned read");
    tx_manual = 1;
    tx_ready  = 0;
    cmd_rd(32'h0000_0080, 0);
    wait_tx();
    tx_ready = 1;
    idle(1);
    tx_ready = 0;
    rstn = 0;
    #1 check("reset mid-op outputs", {tx_valid, bus_req, busy}, 0);
    exp_tx.delete();
    idle(2);
    rstn = 1;
    tx_manual = 0;
    idle(1);
    cmd_wr(32'h0000_0084, 32'hCAFE_F00D, 0);
    wait_done("write after reset");
    cmd_rd(32'h0000_0084, 0);
    wait_done("readback after reset");
    repeat (40) begin
      a = ($urandom % 4 == 0) ? $urandom : (32'h2000_0000 | (($urandom % 8) << 2) | ($urandom % 4));
      d = $urandom;
      case ($urandom % 8)
        0: begin
          b = $urandom;
          if (b == 8'h57 || b == 8'h52) b = 8'h00;
          cmd_bad(b);
        end
        1, 2, 3: cmd_wr(a, d, 1);
        default: cmd_rd(a, 1);
      endcase
      wait_done("random");
      idle($urandom % 3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
